// File: rtl/i2c_target_regfile_if.sv
// i2c_target_regfile_if: Wishbone slave bus bundle for the I2C target register file.
interface i2c_target_regfile_if;
    logic [4:0]  adr_i;
    logic [31:0] dat_i;
    logic        we_i;
    logic        cyc_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;
    modport master (output adr_i, dat_i, we_i, cyc_i, stb_i, input dat_o, ack_o, err_o, rty_o);
    modport slave  (input adr_i, dat_i, we_i, cyc_i, stb_i, output dat_o, ack_o, err_o, rty_o);
endinterface

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target exposing a 16x8 register file, shared with a Wishbone slave port.
module i2c_target_regfile #(
    parameter logic [6:0] I2C_ADDR   = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                sda_o,
    output logic                sda_oe,
    i2c_target_regfile_if.slave wb,
    output logic                irq_o
);
    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE} state_t;
    localparam logic [3:0] FL = 4'(FILTER_LEN - 1);
    logic [1:0] rst_q;
    logic       rst;
    logic [1:0] scl_s_q, sda_s_q;
    logic [3:0] scl_c_q, sda_c_q;
    logic       scl_f_q, sda_f_q, scl_p_q, sda_p_q;
    logic       scl_rise, scl_fall, start, stop;
    state_t     state_q;
    logic [7:0] sh_q;
    logic [7:0] byte_w;
    logic [3:0] cnt_q, ptr_q, last_ptr_q;
    logic       rw_q, sda_oe_q, wr_pend_q, wr_done_q, irq_en_q, busy;
    logic [7:0] regs_q [16];
    logic       ack_q, wb_req, wb_wr;
    logic [31:0] dat_o_q, rd_data, status;
    logic       unused_ok;
    // Reset asserts asynchronously but releases two clocks later, in step with wb_clk.
    always_ff @(posedge wb_clk or posedge wb_rst)
        if (wb_rst) rst_q <= 2'b11;
        else rst_q <= {rst_q[0], 1'b0};
    assign rst = rst_q[1];
    always_ff @(posedge wb_clk or posedge rst)
        if (rst) begin
            scl_s_q <= 2'b11;
            sda_s_q <= 2'b11;
            scl_c_q <= '0;
            sda_c_q <= '0;
            scl_f_q <= 1'b1;
            sda_f_q <= 1'b1;
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_s_q <= {scl_s_q[0], scl_i};
            sda_s_q <= {sda_s_q[0], sda_i};
            if (scl_s_q[1] == scl_f_q) scl_c_q <= '0;
            else if (scl_c_q == FL) begin
                scl_f_q <= scl_s_q[1];
                scl_c_q <= '0;
            end else scl_c_q <= scl_c_q + 4'd1;
            if (sda_s_q[1] == sda_f_q) sda_c_q <= '0;
            else if (sda_c_q == FL) begin
                sda_f_q <= sda_s_q[1];
                sda_c_q <= '0;
            end else sda_c_q <= sda_c_q + 4'd1;
            scl_p_q <= scl_f_q;
            sda_p_q <= sda_f_q;
        end
    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign start    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
    assign stop     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
    assign byte_w   = {sh_q[6:0], sda_f_q};
    assign wb_req   = wb.cyc_i & wb.stb_i & ~ack_q;
    assign wb_wr    = wb_req & wb.we_i;
    assign busy     = state_q != IDLE && state_q != IGNORE;
    // WB updates come first so a same-cycle I2C write or STOP set overrides them.
    always_ff @(posedge wb_clk or posedge rst)
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            last_ptr_q <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            if (wb_wr && !wb.adr_i[4]) regs_q[wb.adr_i[3:0]] <= wb.dat_i[7:0];
            if (wb_wr && wb.adr_i == 5'd16) begin
                if (wb.dat_i[0]) wr_done_q <= 1'b0;
                irq_en_q <= wb.dat_i[31];
            end
            if (stop) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                if (wr_pend_q) begin
                    wr_done_q  <= 1'b1;
                    last_ptr_q <= ptr_q - 4'd1;
                    wr_pend_q  <= 1'b0;
                end
            end else if (start) begin
                state_q  <= ADDR;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
            end else case (state_q)
                ADDR, PTR, WDATA: if (scl_rise) begin
                    sh_q  <= byte_w;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_q <= '0;
                        if (state_q == ADDR) begin
                            state_q <= byte_w[7:1] == I2C_ADDR ? ADDR_ACK : IGNORE;
                            rw_q    <= byte_w[0];
                        end else if (state_q == PTR) begin
                            ptr_q   <= byte_w[3:0];
                            state_q <= PTR_ACK;
                        end else begin
                            regs_q[ptr_q] <= byte_w;
                            ptr_q     <= ptr_q + 4'd1;
                            wr_pend_q <= 1'b1;
                            state_q   <= WDATA_ACK;
                        end
                    end
                end
                // First falling edge drives the ACK, the second ends the ACK slot.
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe_q) sda_oe_q <= 1'b1;
                    else if (state_q == ADDR_ACK && rw_q) begin
                        sda_oe_q <= ~regs_q[ptr_q][7];
                        sh_q     <= {regs_q[ptr_q][6:0], 1'b0};
                        cnt_q    <= '0;
                        state_q  <= RDATA;
                    end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= state_q == ADDR_ACK ? PTR : WDATA;
                    end
                end
                RDATA: if (scl_rise) cnt_q <= cnt_q + 4'd1;
                else if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= RACK;
                    end else begin
                        sda_oe_q <= ~sh_q[7];
                        sh_q     <= {sh_q[6:0], 1'b0};
                    end
                end
                RACK: if (scl_rise) begin
                    if (!sda_f_q) begin
                        ptr_q   <= ptr_q + 4'd1;
                        sh_q    <= regs_q[ptr_q + 4'd1];
                        cnt_q   <= '0;
                        state_q <= RDATA;
                    end else state_q <= IGNORE;
                end
                default: ;
            endcase
        end
    assign status  = {irq_en_q, 19'd0, last_ptr_q, 6'd0, busy, wr_done_q};
    assign rd_data = !wb.adr_i[4] ? {24'd0, regs_q[wb.adr_i[3:0]]} : wb.adr_i == 5'd16 ? status : '0;
    always_ff @(posedge wb_clk or posedge rst)
        if (rst) begin
            ack_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            ack_q <= wb_req;
            if (wb_req) dat_o_q <= rd_data;
        end
    assign sda_o     = 1'b0;
    assign sda_oe    = sda_oe_q;
    assign irq_o     = wr_done_q & irq_en_q;
    assign wb.dat_o  = dat_o_q;
    assign wb.ack_o  = ack_q;
    assign wb.err_o  = 1'b0;
    assign wb.rty_o  = 1'b0;
    assign unused_ok = ^wb.dat_i[30:1];
endmodule
